// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS crop window: coordinate width, FSM
// state encoding and the default sensor/crop geometry.
package cmos_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_ACT   = 640;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_X_START = 0;
  localparam int DEF_Y_START = 0;
  localparam int DEF_CROP_W  = 640;
  localparam int DEF_CROP_H  = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_LINE   = 2'd2,
    ST_HBLANK = 2'd3
  } crop_state_e;

endpackage

// File: rtl/sig_edge_det.sv
// Registered edge detector: keeps last cycle's level and flags
// rising/falling transitions of the live input against it.
module sig_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Previous-cycle sample of the input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sig_q <= 1'b0;
    else         sig_q <= sig_i;
  end

  assign q_o    = sig_q;
  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/cmos_crop_window.sv
// Crops a rectangular window out of a CMOS RGB565 pixel stream and tags
// each surviving pixel with window-relative coordinates.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | after reset; everything ignored until vsync rises
//   ST_VBLANK | frame started, waiting for the first href
//   ST_LINE   | href high, pixels are counted and cropped
//   ST_HBLANK | between lines, waiting for the next href
module cmos_crop_window
  import cmos_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int X_START = DEF_X_START,
  parameter int Y_START = DEF_Y_START,
  parameter int CROP_W  = DEF_CROP_W,
  parameter int CROP_H  = DEF_CROP_H
) (
  input  logic               cam_pclk,
  input  logic               rst_n,
  input  logic               cmos_frame_vsync,
  input  logic               cmos_frame_href,
  input  logic               cmos_frame_valid,
  input  logic [15:0]        cmos_frame_data,
  output logic               crop_vsync,
  output logic               crop_valid,
  output logic [15:0]        crop_data,
  output logic [COORD_W-1:0] crop_x,
  output logic [COORD_W-1:0] crop_y,
  output logic               frame_done,
  output logic               line_err
);

  localparam coord_t H_ACT_C  = coord_t'(H_ACT);
  localparam coord_t V_ACT_C  = coord_t'(V_ACT);
  localparam coord_t X_START_C = coord_t'(X_START);
  localparam coord_t Y_START_C = coord_t'(Y_START);
  localparam coord_t CROP_W_C = coord_t'(CROP_W);
  localparam coord_t CROP_H_C = coord_t'(CROP_H);
  localparam coord_t LAST_X_C = coord_t'(CROP_W - 1);
  localparam coord_t LAST_Y_C = coord_t'(CROP_H - 1);

  crop_state_e state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  coord_t      rel_x, rel_y;
  logic        err_q, err_d;
  logic        done_seen_q, done_seen_d;
  logic        vs_q, vs_rise, vs_fall;
  logic        hr_q, hr_rise, hr_fall;
  logic        pix_en, line_end, in_win, frame_hit;
  logic        crop_valid_q, frame_done_q;
  logic [15:0] crop_data_q;
  coord_t      crop_x_q, crop_y_q;
  logic        unused_edges;

  sig_edge_det u_vsync_edge (
    .clk_i  (cam_pclk),
    .rst_ni (rst_n),
    .sig_i  (cmos_frame_vsync),
    .q_o    (vs_q),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  sig_edge_det u_href_edge (
    .clk_i  (cam_pclk),
    .rst_ni (rst_n),
    .sig_i  (cmos_frame_href),
    .q_o    (hr_q),
    .rise_o (hr_rise),
    .fall_o (hr_fall)
  );

  assign unused_edges = vs_fall | hr_rise | hr_q;

  // A vsync rise pre-empts anything else happening in the same cycle.
  assign pix_en   = cmos_frame_valid && cmos_frame_href && (state_q == ST_LINE) && !vs_rise;
  assign line_end = (state_q == ST_LINE) && hr_fall && !vs_rise;

  // Modular subtraction: columns left of the window wrap to values
  // >= 2048-X_START, which always exceed CROP_W, so one compare suffices.
  assign rel_x = x_q - X_START_C;
  assign rel_y = y_q - Y_START_C;

  assign in_win    = pix_en && (rel_x < CROP_W_C) && (rel_y < CROP_H_C) && (y_q < V_ACT_C);
  assign frame_hit = in_win && (rel_x == LAST_X_C) && (rel_y == LAST_Y_C) && !done_seen_q;

  // FSM state register
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = ST_VBLANK;
    end else begin
      case (state_q)
        ST_VBLANK: if (cmos_frame_href) state_d = ST_LINE;
        ST_LINE:   if (hr_fall)         state_d = ST_HBLANK;
        ST_HBLANK: if (cmos_frame_href) state_d = ST_LINE;
        default:   state_d = state_q;
      endcase
    end
  end

  // Column/line counters, line-length error and once-per-frame done guard.
  // A pixel arriving when the column count is already saturated means the
  // line is longer than H_ACT, which is flagged immediately.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    err_d       = err_q;
    done_seen_d = done_seen_q;
    if (vs_rise) begin
      x_d         = '0;
      y_d         = '0;
      err_d       = 1'b0;
      done_seen_d = 1'b0;
    end else if (line_end) begin
      if ((x_q != '0) && (y_q < V_ACT_C)) y_d = y_q + coord_t'(1);
      x_d = '0;
      if (x_q != H_ACT_C) err_d = 1'b1;
    end else if (pix_en) begin
      if (x_q != H_ACT_C) x_d = x_q + coord_t'(1);
      else                err_d = 1'b1;
    end
    if (frame_hit) done_seen_d = 1'b1;
  end

  // Counter and flag registers
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      err_q       <= err_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Output pipeline stage; pixel fields hold between valid strobes
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      crop_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      crop_data_q  <= '0;
      crop_x_q     <= '0;
      crop_y_q     <= '0;
    end else begin
      crop_valid_q <= in_win;
      frame_done_q <= frame_hit;
      if (in_win) begin
        crop_data_q <= cmos_frame_data;
        crop_x_q    <= rel_x;
        crop_y_q    <= rel_y;
      end
    end
  end

  assign crop_vsync = vs_q;
  assign crop_valid = crop_valid_q;
  assign crop_data  = crop_data_q;
  assign crop_x     = crop_x_q;
  assign crop_y     = crop_y_q;
  assign frame_done = frame_done_q;
  assign line_err   = err_q;

endmodule

// File: tb/tb_cmos_crop_window.sv
// Directed bench for cmos_crop_window on an 8x4 sensor with a 4x2 window
// at (2,1). Pixel data is y*16+x so every output identifies its source.
module tb_cmos_crop_window;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = 16'h0;
  logic        crop_vsync, crop_valid, frame_done, line_err;
  logic [15:0] crop_data;
  logic [10:0] crop_x, crop_y;

  int n_vec = 0;
  int n_err = 0;

  int          mon_cnt = 0;
  int          mon_done = 0;
  int          mon_orphan = 0;
  logic [15:0] mon_data [256];
  logic [10:0] mon_x [256];
  logic [10:0] mon_y [256];
  logic [15:0] mon_done_data = 16'h0;

  logic [15:0] exp_win [8];

  cmos_crop_window #(
    .H_ACT(8), .V_ACT(4), .X_START(2), .Y_START(1), .CROP_W(4), .CROP_H(2)
  ) dut (
    .cam_pclk         (cam_pclk),
    .rst_n            (rst_n),
    .cmos_frame_vsync (vsync),
    .cmos_frame_href  (href),
    .cmos_frame_valid (valid),
    .cmos_frame_data  (data),
    .crop_vsync       (crop_vsync),
    .crop_valid       (crop_valid),
    .crop_data        (crop_data),
    .crop_x           (crop_x),
    .crop_y           (crop_y),
    .frame_done       (frame_done),
    .line_err         (line_err)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Output monitor, sampled on the falling edge
  always @(negedge cam_pclk) begin
    if (crop_valid) begin
      mon_data[mon_cnt & 255] <= crop_data;
      mon_x[mon_cnt & 255]    <= crop_x;
      mon_y[mon_cnt & 255]    <= crop_y;
      mon_cnt <= mon_cnt + 1;
    end
    if (frame_done) begin
      mon_done      <= mon_done + 1;
      mon_done_data <= crop_data;
      if (!crop_valid) mon_orphan <= mon_orphan + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge cam_pclk);
  endtask

  task automatic vs_pulse();
    step(); vsync = 1'b1;
    step(); chk("crop_vsync_high", 32'(crop_vsync), 32'd1);
    step(); vsync = 1'b0;
    step(); step();
  endtask

  task automatic send_line(input int y, input int npix, input bit hb_valid);
    step(); href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      step(); valid = 1'b1; data = 16'(y * 16 + i);
    end
    step(); valid = 1'b0; href = 1'b0;
    step(); if (hb_valid) valid = 1'b1;
    step(); valid = 1'b0;
    step();
  endtask

  // Complete 8x4 frame with stray strobes in VBLANK and after line 0
  task automatic full_frame();
    vs_pulse();
    step(); valid = 1'b1; data = 16'hdead;
    step(); valid = 1'b0;
    step();
    for (int y = 0; y < 4; y++) send_line(y, 8, y == 0);
    step(); step();
  endtask

  task automatic chk_frame(input string tag, input int c0, input int d0);
    chk({tag, "_cnt"}, 32'(mon_cnt - c0), 32'd8);
    chk({tag, "_done"}, 32'(mon_done - d0), 32'd1);
    chk({tag, "_done_data"}, 32'(mon_done_data), 32'h25);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_d%0d", tag, i), 32'(mon_data[(c0 + i) & 255]), 32'(exp_win[i]));
  endtask

  initial begin
    int c0, d0;
    exp_win = '{16'h12, 16'h13, 16'h14, 16'h15, 16'h22, 16'h23, 16'h24, 16'h25};

    // Reset values
    step(); step();
    chk("rst_valid", 32'(crop_valid), 32'd0);
    chk("rst_data", 32'(crop_data), 32'd0);
    chk("rst_x", 32'(crop_x), 32'd0);
    chk("rst_y", 32'(crop_y), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(line_err), 32'd0);
    chk("rst_vsync", 32'(crop_vsync), 32'd0);
    step(); rst_n = 1'b1;
    step();

    // IDLE ignores lines before the first vsync
    c0 = mon_cnt;
    for (int y = 0; y < 3; y++) send_line(y, 8, 1'b0);
    chk("idle_cnt", 32'(mon_cnt - c0), 32'd0);
    chk("idle_err", 32'(line_err), 32'd0);

    // Full frame with stray blanking strobes
    c0 = mon_cnt; d0 = mon_done;
    full_frame();
    chk_frame("f1", c0, d0);
    chk("f1_x0", 32'(mon_x[c0 & 255]), 32'd0);
    chk("f1_y0", 32'(mon_y[c0 & 255]), 32'd0);
    chk("f1_x7", 32'(mon_x[(c0 + 7) & 255]), 32'd3);
    chk("f1_y7", 32'(mon_y[(c0 + 7) & 255]), 32'd1);
    chk("f1_err", 32'(line_err), 32'd0);
    chk("f1_hold_valid", 32'(crop_valid), 32'd0);
    chk("f1_hold_data", 32'(crop_data), 32'h25);
    chk("f1_hold_x", 32'(crop_x), 32'd3);
    chk("f1_hold_y", 32'(crop_y), 32'd1);

    // Short line 2 -> sticky line_err, cleared by next vsync
    c0 = mon_cnt; d0 = mon_done;
    vs_pulse();
    send_line(0, 8, 1'b0);
    send_line(1, 8, 1'b0);
    chk("short_err_before", 32'(line_err), 32'd0);
    send_line(2, 7, 1'b0);
    chk("short_err_set", 32'(line_err), 32'd1);
    send_line(3, 8, 1'b0);
    chk("short_err_held", 32'(line_err), 32'd1);
    chk_frame("f2", c0, d0);
    vs_pulse();
    chk("short_err_clr", 32'(line_err), 32'd0);

    // Vsync after 1 pixel of line 2 -> no frame_done
    c0 = mon_cnt; d0 = mon_done;
    send_line(0, 8, 1'b0);
    send_line(1, 8, 1'b0);
    step(); href = 1'b1;
    step(); valid = 1'b1; data = 16'h20;
    step(); valid = 1'b0; href = 1'b0; vsync = 1'b1;
    step(); step(); vsync = 1'b0;
    step(); step();
    chk("part_cnt", 32'(mon_cnt - c0), 32'd4);
    chk("part_done", 32'(mon_done - d0), 32'd0);
    c0 = mon_cnt; d0 = mon_done;
    full_frame();
    chk_frame("f3", c0, d0);

    // Reset pulse in the middle of line 1
    vs_pulse();
    send_line(0, 8, 1'b0);
    c0 = mon_cnt;
    step(); href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); valid = 1'b1; data = 16'(16 + i);
    end
    step(); valid = 1'b0;
    step(); rst_n = 1'b0;
    step();
    chk("mrst_cnt_pre", 32'(mon_cnt - c0), 32'd1);
    chk("mrst_data", 32'(crop_data), 32'd0);
    chk("mrst_valid", 32'(crop_valid), 32'd0);
    chk("mrst_vsync", 32'(crop_vsync), 32'd0);
    step(); rst_n = 1'b1;
    c0 = mon_cnt;
    for (int i = 3; i < 8; i++) begin
      step(); valid = 1'b1; data = 16'(16 + i);
    end
    step(); valid = 1'b0; href = 1'b0;
    step();
    send_line(2, 8, 1'b0);
    send_line(3, 8, 1'b0);
    chk("mrst_ignored", 32'(mon_cnt - c0), 32'd0);
    chk("mrst_err", 32'(line_err), 32'd0);
    d0 = mon_done;
    full_frame();
    chk_frame("f4", c0, d0);

    // 10-pixel line plus an extra 5th line
    c0 = mon_cnt; d0 = mon_done;
    vs_pulse();
    send_line(0, 8, 1'b0);
    send_line(1, 10, 1'b0);
    chk("long_err", 32'(line_err), 32'd1);
    send_line(2, 8, 1'b0);
    send_line(3, 8, 1'b0);
    send_line(4, 8, 1'b0);
    chk_frame("f5", c0, d0);
    chk("long_err_held", 32'(line_err), 32'd1);

    chk("orphan_done", 32'(mon_orphan), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
